fifo_push_arb: RTL and testbench
================================

# fifo_push_arb

Round-robin push-side arbiter that lets NREQ producers share one `sync_fifo` write port. Each producer presents a request with data; the arbiter grants at most one per cycle, with optional burst ownership, and drives the FIFO `push`/`din` through a register stage. It uses the FIFO `full`/`a_full` flags so that no write is ever issued into a full FIFO.

## Interface
Parameters:
- NREQ, 4, number of producers (2..16)
- DW, 8, data width; equals `sync_fifo` width
- BURST, 2, maximum consecutive beats one owner may push before rotation (1..255); BURST=1 gives plain per-beat round robin

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req  in  NREQ  per-producer request; the producer holds it with stable data until granted
- req_data  in  NREQ*DW  producer data; producer i occupies bits [i*DW +: DW]
- gnt  out  NREQ  one-hot or zero; gnt[i]=1 means producer i's beat is accepted at this edge
- fifo_push  out  1  registered push to `sync_fifo`
- fifo_din  out  DW  registered data to `sync_fifo`
- fifo_full  in  1  `sync_fifo` full
- fifo_a_full  in  1  `sync_fifo` almost-full; asserted when free slots <= 1
- owner_id  out  clog2(NREQ)  current or most recent owner; for debug

## Operation
- Room check (combinational): room = !fifo_full && !(fifo_a_full && fifo_push). This accounts for the one write already in flight in the output register. The check is conservative with respect to concurrent pops.
- FSM states: ARB_IDLE, ARB_BURST. Registered state includes ptr (rotating priority start), owner, and beat_cnt (8 bit).
- Arbitration (ARB_IDLE, or ARB_BURST with req[owner]=0):
  - Winner is the first i with req[i]=1, searching from ptr upward and wrapping mod NREQ.
  - If room, gnt[winner]=1, owner<=winner and beat_cnt<=1.
  - If BURST=1, the arbiter stays in or returns to ARB_IDLE and sets ptr<=winner+1. Otherwise it goes to ARB_BURST.
  - With no room, or no request, gnt=0 and the state is unchanged. ptr advances only on a grant.
- ARB_BURST with req[owner]=1:
  - Only the owner can be granted. gnt[owner]=room; all other requesters are locked out.
  - On a grant, beat_cnt increments. When the beat count reaches BURST, the arbiter goes to ARB_IDLE with ptr<=owner+1.
  - While there is no room, ownership and count are held. The owner keeps priority through the stall.
- Owner release: if req[owner]=0 while in ARB_BURST, that cycle arbitrates as in ARB_IDLE with search starting at owner+1. The state goes to ARB_IDLE unless a new burst is granted.
- Datapath: on any grant, fifo_push<=1 and fifo_din<=req_data[winner]. Otherwise fifo_push<=0 and fifo_din holds its value.
- Ordering: each producer's beats enter the FIFO in the order it presented them. No beat is dropped or duplicated.

## Timing
- gnt is a combinational function of req, fifo flags and registered state. It has no dependency on req_data.
- Latency: a grant in cycle t gives fifo_push=1 in cycle t+1. The FIFO writes at the end of t+1.
- Throughput: one beat per cycle while room holds.
- With no pops, the FIFO reaches full and there is zero overflow. fifo_push is never 1 in a cycle where fifo_full=1.
- Reset (async, any time):
  - gnt=0, fifo_push=0, fifo_din=0, owner_id=0.
  - state=ARB_IDLE, ptr=0, beat_cnt=0.
  - An in-flight push is discarded.
  - Outputs are valid from the first edge after rstn rises.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum {ARB_IDLE, ARB_BURST}
  - the clog2-derived ID width function
- Sub-module `rr_pick` (NREQ): combinational rotating-priority picker. Inputs are req and ptr; outputs are the one-hot grant and the index.
- The top level contains the FSM, counters, room check and output register. It instantiates `sync_fifo` only in the bench.

## Test plan
Bench: NREQ=4, DW=8, BURST=2, `sync_fifo` DEPTH=4.
- Single requester: req[1]=1 presenting 0xA0, 0xA1, 0xA2 with no pops -> gnt[1] for 3 cycles. fifo_push follows one cycle later with 0xA0, 0xA1, 0xA2 in order. `empty` deasserts after the first write.
- All four requesting continuously, pops every cycle, producer i sending 0x10*i+n -> grant order is 0,0,1,1,2,2,3,3,0,0. Dout follows the same order.
- Backpressure: all requesting, no pops -> exactly 4 writes. gnt stays 0 while fifo_full=1 and no push occurs. After one pop, exactly one further grant is issued.
- Owner release: req[2] drops after one beat of its burst while req[3]=1 -> gnt[3] in the same cycle. ptr then moves to 0.
- Stall mid-burst: owner 0 has beat_cnt=1 and the FIFO fills; req[1] is also high -> gnt[1] never asserts during the stall. After a pop, gnt[0] takes the second beat before any rotation.
- Reset mid-operation: pull rstn low during an active burst with a push in flight -> gnt=0, fifo_push=0 and fifo_din=0 immediately. After release, the first grant goes to the lowest-indexed requester (ptr=0).

Source files
------------

// File: rtl/fifo_push_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg
// Shared types and helpers for the round-robin FIFO push arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width of a producer index; never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arb_if.sv
// ============================================================================
// fifo_push_arb_if
// Producer request/data and FIFO write-port bundle for fifo_push_arb.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_push_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_push;
  logic [DW-1:0]      fifo_din;
  logic               fifo_full;
  logic               fifo_a_full;
  logic [IDW-1:0]     owner_id;

  modport master (
    output req, req_data, fifo_full, fifo_a_full,
    input  gnt, fifo_push, fifo_din, owner_id
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_a_full,
    output gnt, fifo_push, fifo_din, owner_id
  );

endinterface

`default_nettype wire

// File: rtl/fifo_push_arb_rr_pick.sv
// ============================================================================
// rr_pick
// Combinational rotating-priority picker: first request at or above ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin : p_pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan from farthest to nearest so the nearest hit is the last write.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arb.sv
// ============================================================================
// fifo_push_arb
// Round-robin push arbiter with burst ownership feeding one sync_fifo port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 2
) (
  input  logic            clk,
  input  logic            rstn,
  fifo_push_arb_if.slave  bus
);

  localparam int             IDW       = id_width(NREQ);
  localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);
  localparam logic [7:0]     c_burst   = 8'(BURST);

  arb_state_e     r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt;
  logic [7:0]     r_beat_cnt, w_beat_nxt;
  logic           r_push;
  logic [DW-1:0]  r_din;

  logic            w_room;
  logic [IDW-1:0]  w_owner_inc, w_pick_inc, w_search, w_pick_idx, w_win;
  logic [NREQ-1:0] w_pick_oh, w_gnt;
  logic            w_pick_any;

  // A push already sitting in the output register will consume the last slot.
  assign w_room      = !bus.fifo_full && !(bus.fifo_a_full && r_push);
  assign w_owner_inc = (r_owner == c_last_id) ? '0 : r_owner + 1'b1;
  assign w_pick_inc  = (w_pick_idx == c_last_id) ? '0 : w_pick_idx + 1'b1;
  assign w_search    = (r_state == ARB_BURST) ? w_owner_inc : r_ptr;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (w_search),
    .gnt (w_pick_oh),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_comb begin
    w_gnt       = '0;
    w_win       = r_owner;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat_cnt;
    if (r_state == ARB_BURST && bus.req[r_owner]) begin
      if (w_room) begin
        w_gnt[r_owner] = 1'b1;
        w_beat_nxt     = r_beat_cnt + 8'd1;
        if (w_beat_nxt == c_burst) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = w_owner_inc;
        end
      end
    end else begin
      w_state_nxt = ARB_IDLE;
      if (w_pick_any && w_room) begin
        w_gnt       = w_pick_oh;
        w_win       = w_pick_idx;
        w_owner_nxt = w_pick_idx;
        w_beat_nxt  = 8'd1;
        // Pointer moves past every newly granted owner.
        w_ptr_nxt   = w_pick_inc;
        w_state_nxt = (BURST == 1) ? ARB_IDLE : ARB_BURST;
      end
    end
    if (!rstn) w_gnt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_push     <= 1'b0;
      r_din      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_push     <= |w_gnt;
      if (|w_gnt) r_din <= bus.req_data[w_win*DW +: DW];
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.fifo_push = r_push;
  assign bus.fifo_din  = r_din;
  assign bus.owner_id  = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arb.sv
// ============================================================================
// tb_fifo_push_arb
// Self-checking bench: behavioural arbiter + FIFO model, directed and random.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_push_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 2;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_push_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_push_arb #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int base[NREQ];
  int n[NREQ];

  // Reference state: who owns a burst, beats taken, rotation start.
  int            m_ptr, m_owner, m_cnt;
  bit            m_burst, m_push;
  logic [DW-1:0] m_din;
  logic [DW-1:0] fq[$];

  logic [NREQ-1:0] last_gnt, r, pend;
  int              push_cnt;
  logic [DW-1:0]   dlog[$];
  int              exp_c[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0; m_push = 0; m_din = '0;
    fq.delete();
  endtask

  task automatic cycle(input logic [NREQ-1:0] rq, input bit pop);
    int            win, start, pre;
    bit            room, full, afull, old_push;
    logic [DW-1:0] old_din;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    full  = (fq.size() == DEPTH);
    afull = ((DEPTH - fq.size()) <= 1);
    bus.req         = rq;
    bus.fifo_full   = full;
    bus.fifo_a_full = afull;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = DW'(base[i] + n[i]);
    #1;
    chk("fifo_push", 32'(bus.fifo_push), 32'(m_push));
    chk("fifo_din", 32'(bus.fifo_din), 32'(m_din));
    chk("owner_id", 32'(bus.owner_id), 32'(m_owner));
    chk("push_into_full", 32'(bus.fifo_push && full), 32'd0);
    if (bus.fifo_push) begin
      push_cnt++;
      dlog.push_back(bus.fifo_din);
    end
    old_push = m_push;
    old_din  = m_din;
    room = !full && !(afull && m_push);
    win  = -1;
    if (m_burst && rq[m_owner]) begin
      if (room) begin
        win = m_owner;
        m_cnt++;
        if (m_cnt == BURST) begin
          m_burst = 0;
          m_ptr   = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      start   = m_burst ? (m_owner + 1) % NREQ : m_ptr;
      m_burst = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (start + k) % NREQ;
        if (win < 0 && rq[c]) win = c;
      end
      if (!room) win = -1;
      if (win >= 0) begin
        m_owner = win;
        m_cnt   = 1;
        m_ptr   = (win + 1) % NREQ;
        m_burst = (BURST > 1);
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    last_gnt = bus.gnt;
    m_push = (win >= 0);
    if (win >= 0) m_din = DW'(base[win] + n[win]);
    @(posedge clk);
    pre = fq.size();
    if (pop && pre > 0) void'(fq.pop_front());
    if (old_push && pre < DEPTH) fq.push_back(old_din);
    if (win >= 0) n[win]++;
  endtask

  task automatic do_reset(input logic [NREQ-1:0] rq);
    @(negedge clk);
    bus.req = rq;
    rstn    = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_push", 32'(bus.fifo_push), 32'd0);
    chk("rst_din", 32'(bus.fifo_din), 32'd0);
    chk("rst_owner", 32'(bus.owner_id), 32'd0);
    bus.req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bus.req         = '0;
    bus.req_data    = '0;
    bus.fifo_full   = 1'b0;
    bus.fifo_a_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin base[i] = 16 * i; n[i] = 0; end
    model_reset();
    do_reset('0);

    // Single requester, three beats, no pops.
    base[1] = 8'hA0; n[1] = 0;
    dlog.delete();
    repeat (3) begin
      cycle(4'b0010, 1'b0);
      chk("single_gnt", 32'(last_gnt), 32'h2);
    end
    repeat (2) cycle(4'b0000, 1'b0);
    chk("single_writes", dlog.size(), 3);
    for (int i = 0; i < 3; i++) chk("single_data", 32'(dlog[i]), 32'hA0 + i);

    // All requesting with pops: burst-of-two rotation.
    do_reset('0);
    for (int i = 0; i < NREQ; i++) begin base[i] = 16 * i; n[i] = 0; end
    for (int k = 0; k < 10; k++) begin
      cycle(4'b1111, 1'b1);
      chk("rr_order", 32'(last_gnt), 32'd1 << exp_c[k]);
    end
    repeat (2) cycle(4'b0000, 1'b1);

    // Backpressure: no pops fills exactly DEPTH entries.
    do_reset('0);
    push_cnt = 0;
    repeat (12) cycle(4'b1111, 1'b0);
    chk("bp_writes", push_cnt, 4);
    push_cnt = 0;
    cycle(4'b1111, 1'b1);
    repeat (6) cycle(4'b1111, 1'b0);
    chk("bp_after_pop", push_cnt, 1);

    // Owner release hands the cycle to the next requester.
    do_reset('0);
    cycle(4'b1100, 1'b1);
    chk("rel_first", 32'(last_gnt), 32'b0100);
    cycle(4'b1000, 1'b1);
    chk("rel_handoff", 32'(last_gnt), 32'b1000);
    cycle(4'b0011, 1'b1);
    chk("rel_wrap", 32'(last_gnt), 32'b0001);
    cycle(4'b0000, 1'b1);

    // Stall mid-burst: owner 0 keeps priority over producer 1.
    do_reset('0);
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    cycle(4'b1001, 1'b0);
    chk("stall_p3", 32'(last_gnt), 32'b1000);
    cycle(4'b0011, 1'b0);
    chk("stall_start", 32'(last_gnt), 32'b0001);
    repeat (4) begin
      cycle(4'b0011, 1'b0);
      chk("stall_gnt", 32'(last_gnt), 32'd0);
    end
    cycle(4'b0011, 1'b1);
    chk("stall_gnt", 32'(last_gnt), 32'd0);
    cycle(4'b0011, 1'b0);
    chk("stall_resume", 32'(last_gnt), 32'b0001);

    // Reset with a push in flight.
    do_reset('0);
    base[0] = 8'h55; n[0] = 0;
    cycle(4'b0011, 1'b1);
    chk("mid_gnt", 32'(last_gnt), 32'b0001);
    do_reset(4'b0011);
    cycle(4'b1010, 1'b1);
    chk("post_rst_gnt", 32'(last_gnt), 32'b0010);

    // Random traffic; requests hold until granted.
    do_reset('0);
    pend = '0;
    repeat (800) begin
      for (int i = 0; i < NREQ; i++) r[i] = pend[i] | ($urandom_range(0, 3) != 0);
      cycle(r, 1'($urandom_range(0, 1)));
      pend = r & ~last_gnt;
    end
    repeat (6) cycle(4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
